// File: rtl/pa_clic_scan_arb_pkg.sv
// Shared CLIC definitions for the scanning interrupt arbiter: field widths,
// default sizing, FSM state type and the candidate record carried across a sweep.
package pa_clic_scan_arb_pkg;

    localparam int unsigned CLIC_IL_W       = 8;
    localparam int unsigned CLIC_ID_W       = 12;
    localparam int unsigned CLIC_INTNUM_DEF = 128;
    localparam int unsigned CLIC_GRP_DEF    = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

    typedef struct packed {
        logic                 vld;
        logic [CLIC_ID_W-1:0] id;
        logic [CLIC_IL_W-1:0] il;
        logic                 hv;
    } clic_cand_t;

endpackage

// File: rtl/pa_clic_grp_cmp.sv
// Combinational GRP-way compare: picks the qualifying source (req && il > thresh)
// with the highest level; on equal levels the lowest local index wins.
module pa_clic_grp_cmp
    import pa_clic_scan_arb_pkg::*;
#(
    parameter int unsigned GRP = CLIC_GRP_DEF
) (
    input  logic [GRP-1:0]           grp_req,
    input  logic [GRP*CLIC_IL_W-1:0] grp_il,
    input  logic [GRP-1:0]           grp_hv,
    input  logic [CLIC_IL_W-1:0]     thresh,
    output logic                     win_vld,
    output logic [$clog2(GRP)-1:0]   win_idx,
    output logic [CLIC_IL_W-1:0]     win_il,
    output logic                     win_hv
);

    localparam int unsigned LW = $clog2(GRP);

    // Ascending scan; only a strictly greater level displaces the current pick,
    // which gives lowest-index tie-breaking.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        win_il  = '0;
        win_hv  = 1'b0;
        for (int unsigned i = 0; i < GRP; i++) begin
            if (grp_req[i] && (grp_il[i*CLIC_IL_W +: CLIC_IL_W] > thresh) &&
                (!win_vld || (grp_il[i*CLIC_IL_W +: CLIC_IL_W] > win_il))) begin
                win_vld = 1'b1;
                win_idx = LW'(i);
                win_il  = grp_il[i*CLIC_IL_W +: CLIC_IL_W];
                win_hv  = grp_hv[i];
            end
        end
    end

endmodule

// File: rtl/pa_clic_scan_arb.sv
// Time-multiplexed CLIC arbiter: sweeps the kid request/level vectors one group
// per cycle, keeps a running winner and publishes it at the end of each sweep.
module pa_clic_scan_arb
    import pa_clic_scan_arb_pkg::*;
#(
    parameter int unsigned INTNUM = CLIC_INTNUM_DEF,
    parameter int unsigned GRP    = CLIC_GRP_DEF
) (
    input  logic                        forever_cpuclk,
    input  logic                        cpurst,
    input  logic                        scan_en,
    input  logic                        scan_restart,
    input  logic [INTNUM-1:0]           kid_int_req,
    input  logic [INTNUM*CLIC_IL_W-1:0] kid_int_il,
    input  logic [INTNUM-1:0]           kid_int_hv,
    input  logic [CLIC_IL_W-1:0]        ctrl_int_thresh,
    input  logic                        ctrl_int_ack,
    output logic                        arb_int_vld,
    output logic [CLIC_ID_W-1:0]        arb_int_id,
    output logic [CLIC_IL_W-1:0]        arb_int_il,
    output logic                        arb_int_hv,
    output logic                        arb_sweep_done
);

    localparam int unsigned NGRP = INTNUM / GRP;
    localparam int unsigned GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int unsigned LW   = $clog2(GRP);

    scan_state_e                state_q, state_nxt;
    logic [GW-1:0]              grp_idx;
    clic_cand_t                 best_q;
    clic_cand_t                 grp_cand;
    clic_cand_t                 merged;
    int unsigned                grp_base;
    logic                       last_grp;
    logic                       do_step;
    logic                       do_pub;
    logic                       do_clear;

    logic [GRP-1:0]             grp_req;
    logic [GRP*CLIC_IL_W-1:0]   grp_il;
    logic [GRP-1:0]             grp_hv;
    logic                       win_vld;
    logic [LW-1:0]              win_idx;
    logic [CLIC_IL_W-1:0]       win_il;
    logic                       win_hv;

    // Select the live slice of the kid vectors for the current group.
    always_comb begin
        grp_base = 32'(grp_idx) * GRP;
        grp_req  = kid_int_req[grp_base +: GRP];
        grp_il   = kid_int_il[grp_base*CLIC_IL_W +: GRP*CLIC_IL_W];
        grp_hv   = kid_int_hv[grp_base +: GRP];
        last_grp = (grp_idx == GW'(NGRP - 1));
    end

    pa_clic_grp_cmp #(
        .GRP (GRP)
    ) u_grp_cmp (
        .grp_req (grp_req),
        .grp_il  (grp_il),
        .grp_hv  (grp_hv),
        .thresh  (ctrl_int_thresh),
        .win_vld (win_vld),
        .win_idx (win_idx),
        .win_il  (win_il),
        .win_hv  (win_hv)
    );

    // Merge the group winner into the running best; earlier groups keep ties.
    always_comb begin
        grp_cand.vld = win_vld;
        grp_cand.id  = CLIC_ID_W'(grp_base) + CLIC_ID_W'(win_idx);
        grp_cand.il  = win_il;
        grp_cand.hv  = win_hv;
        merged       = best_q;
        if (win_vld && (!best_q.vld || (win_il > best_q.il))) begin
            merged = grp_cand;
        end
    end

    // FSM state register.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state and sweep control; restart and scan_en drop both pre-empt a publish.
    always_comb begin
        state_nxt = state_q;
        do_step   = 1'b0;
        do_pub    = 1'b0;
        do_clear  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (scan_en) begin
                    state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!scan_en) begin
                    state_nxt = ST_IDLE;
                    do_clear  = 1'b1;
                end else if (scan_restart) begin
                    do_clear  = 1'b1;
                end else if (last_grp) begin
                    do_pub    = 1'b1;
                    do_clear  = 1'b1;
                end else begin
                    do_step   = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                do_clear  = 1'b1;
            end
        endcase
    end

    // Group counter and running best.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            grp_idx <= '0;
            best_q  <= '0;
        end else if (do_clear) begin
            grp_idx <= '0;
            best_q  <= '0;
        end else if (do_step) begin
            grp_idx <= grp_idx + 1'b1;
            best_q  <= merged;
        end
    end

    // Published result; a publish takes priority over an ack in the same cycle.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            arb_int_vld    <= 1'b0;
            arb_int_id     <= '0;
            arb_int_il     <= '0;
            arb_int_hv     <= 1'b0;
            arb_sweep_done <= 1'b0;
        end else begin
            arb_sweep_done <= do_pub;
            if (do_pub) begin
                arb_int_vld <= merged.vld;
                arb_int_id  <= merged.vld ? merged.id : '0;
                arb_int_il  <= merged.vld ? merged.il : '0;
                arb_int_hv  <= merged.vld & merged.hv;
            end else if (ctrl_int_ack) begin
                arb_int_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pa_clic_scan_arb.sv
// Self-checking bench for pa_clic_scan_arb: directed scenarios plus random
// stimulus, compared every cycle against a sweep-level reference model.
module tb_pa_clic_scan_arb;

    localparam int unsigned INTNUM = 128;
    localparam int unsigned GRP    = 16;
    localparam int unsigned NGRP   = INTNUM / GRP;
    localparam int unsigned SN     = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 scan_en;
    logic                 scan_restart;
    logic                 ack;
    logic [INTNUM-1:0]    req;
    logic [INTNUM*8-1:0]  il;
    logic [INTNUM-1:0]    hv;
    logic [7:0]           thresh;

    logic        a_vld, a_hv, a_done;
    logic [11:0] a_id;
    logic [7:0]  a_il;
    logic        s_vld, s_hv, s_done;
    logic [11:0] s_id;
    logic [7:0]  s_il;

    always #5 clk = ~clk;

    pa_clic_scan_arb #(
        .INTNUM (INTNUM),
        .GRP    (GRP)
    ) u_dut (
        .forever_cpuclk  (clk),
        .cpurst          (rst),
        .scan_en         (scan_en),
        .scan_restart    (scan_restart),
        .kid_int_req     (req),
        .kid_int_il      (il),
        .kid_int_hv      (hv),
        .ctrl_int_thresh (thresh),
        .ctrl_int_ack    (ack),
        .arb_int_vld     (a_vld),
        .arb_int_id      (a_id),
        .arb_int_il      (a_il),
        .arb_int_hv      (a_hv),
        .arb_sweep_done  (a_done)
    );

    pa_clic_scan_arb #(
        .INTNUM (SN),
        .GRP    (SN)
    ) u_dut_one (
        .forever_cpuclk  (clk),
        .cpurst          (rst),
        .scan_en         (scan_en),
        .scan_restart    (scan_restart),
        .kid_int_req     (req[SN-1:0]),
        .kid_int_il      (il[SN*8-1:0]),
        .kid_int_hv      (hv[SN-1:0]),
        .ctrl_int_thresh (thresh),
        .ctrl_int_ack    (ack),
        .arb_int_vld     (s_vld),
        .arb_int_id      (s_id),
        .arb_int_il      (s_il),
        .arb_int_hv      (s_hv),
        .arb_sweep_done  (s_done)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: snapshot each source in the cycle its group is visited,
    // then pick the global winner over the whole snapshot at sweep end.
    bit          m_scan;
    int          m_pos;
    bit          seen_q  [INTNUM];
    logic [7:0]  seen_il [INTNUM];
    bit          seen_hv [INTNUM];
    logic        m_vld, m_hv, m_done;
    logic [11:0] m_id;
    logic [7:0]  m_il;

    bit          o_scan;
    logic        o_vld, o_hv, o_done;
    logic [11:0] o_id;
    logic [7:0]  o_il;

    function automatic logic [7:0] il_of(int k);
        return il[k*8 +: 8];
    endfunction

    task automatic model_update();
        bit pub;
        int best;
        if (rst) begin
            m_scan = 0; m_pos = 0;
            m_vld = 0; m_id = 0; m_il = 0; m_hv = 0; m_done = 0;
            o_scan = 0;
            o_vld = 0; o_id = 0; o_il = 0; o_hv = 0; o_done = 0;
            return;
        end
        // wide instance
        pub = 0;
        m_done = 0;
        if (!m_scan) begin
            if (scan_en) begin
                m_scan = 1;
                m_pos  = 0;
            end
        end else if (!scan_en) begin
            m_scan = 0;
            m_pos  = 0;
        end else if (scan_restart) begin
            m_pos = 0;
        end else begin
            for (int j = 0; j < int'(GRP); j++) begin
                int k;
                k = m_pos * int'(GRP) + j;
                seen_q[k]  = req[k] && (il_of(k) > thresh);
                seen_il[k] = il_of(k);
                seen_hv[k] = hv[k];
            end
            if (m_pos == int'(NGRP) - 1) begin
                best = -1;
                for (int k = 0; k < int'(INTNUM); k++)
                    if (seen_q[k] && (best < 0 || seen_il[k] > seen_il[best])) best = k;
                if (best >= 0) begin
                    m_vld = 1; m_id = 12'(best); m_il = seen_il[best]; m_hv = seen_hv[best];
                end else begin
                    m_vld = 0; m_id = 0; m_il = 0; m_hv = 0;
                end
                pub    = 1;
                m_done = 1;
                m_pos  = 0;
            end else begin
                m_pos++;
            end
        end
        if (ack && !pub) m_vld = 0;

        // single-group instance: every scanning cycle publishes the live max
        pub = 0;
        o_done = 0;
        if (!o_scan) begin
            if (scan_en) o_scan = 1;
        end else if (!scan_en) begin
            o_scan = 0;
        end else if (!scan_restart) begin
            best = -1;
            for (int k = 0; k < int'(SN); k++)
                if (req[k] && il_of(k) > thresh && (best < 0 || il_of(k) > il_of(best))) best = k;
            if (best >= 0) begin
                o_vld = 1; o_id = 12'(best); o_il = il_of(best); o_hv = hv[best];
            end else begin
                o_vld = 0; o_id = 0; o_il = 0; o_hv = 0;
            end
            pub    = 1;
            o_done = 1;
        end
        if (ack && !pub) o_vld = 0;
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        chk("vld",   32'(a_vld),  32'(m_vld));
        chk("id",    32'(a_id),   32'(m_id));
        chk("il",    32'(a_il),   32'(m_il));
        chk("hv",    32'(a_hv),   32'(m_hv));
        chk("done",  32'(a_done), 32'(m_done));
        chk("s_vld", 32'(s_vld),  32'(o_vld));
        chk("s_id",  32'(s_id),   32'(o_id));
        chk("s_il",  32'(s_il),   32'(o_il));
        chk("s_hv",  32'(s_hv),   32'(o_hv));
        chk("s_done",32'(s_done), 32'(o_done));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_srcs();
        req = '0;
        il  = '0;
        hv  = '0;
    endtask

    task automatic set_src(input int k, input logic [7:0] v, input logic h);
        req[k]       = 1'b1;
        il[k*8 +: 8] = v;
        hv[k]        = h;
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < 20 && m_pos != p; i++) step();
    endtask

    task automatic rnd_inputs();
        rst          = ($urandom_range(0, 299) == 0);
        scan_en      = ($urandom_range(0, 79) != 0);
        scan_restart = ($urandom_range(0, 39) == 0);
        ack          = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 49) == 0)
            thresh = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                 : 8'($urandom_range(0, 48));
        for (int n = 0; n < 4; n++) begin
            int k;
            k      = int'($urandom_range(0, INTNUM - 1));
            req[k] = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       il[k*8 +: 8] = 8'h60;
                1:       il[k*8 +: 8] = 8'h61;
                default: il[k*8 +: 8] = 8'($urandom);
            endcase
            hv[k] = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        int cnt;
        int found;
        rst = 1; scan_en = 0; scan_restart = 0; ack = 0; thresh = 8'h00;
        clear_srcs();
        run(2);
        chk("rst_vld",  32'(a_vld),  0);
        chk("rst_id",   32'(a_id),   0);
        chk("rst_done", 32'(a_done), 0);

        // single source, first-publish latency and done cadence
        set_src(37, 8'h80, 1'b1);
        scan_en = 1;
        rst     = 0;
        run(8);
        chk("t1_early_vld", 32'(a_vld), 0);
        step();
        chk("t1_vld",  32'(a_vld),  1);
        chk("t1_id",   32'(a_id),   37);
        chk("t1_il",   32'(a_il),   32'h80);
        chk("t1_done", 32'(a_done), 1);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (a_done) cnt++;
        end
        chk("t1_done_cnt", cnt, 2);

        // tie across groups goes to the lower id, then a strictly higher level wins
        clear_srcs();
        set_src(5,   8'h60, 1'b0);
        set_src(100, 8'h60, 1'b1);
        run(16);
        chk("tie_id", 32'(a_id), 5);
        il[100*8 +: 8] = 8'h61;
        run(16);
        chk("raise_id", 32'(a_id), 100);
        chk("raise_hv", 32'(a_hv), 1);

        // threshold is strict
        clear_srcs();
        set_src(20, 8'h40, 1'b0);
        thresh = 8'h40;
        run(16);
        chk("thr_eq_vld", 32'(a_vld), 0);
        thresh = 8'h3F;
        run(16);
        chk("thr_vld", 32'(a_vld), 1);
        chk("thr_id",  32'(a_id),  20);

        // ack away from a publish edge
        if (m_pos == int'(NGRP) - 1) step();
        ack = 1;
        step();
        ack = 0;
        chk("ack_vld", 32'(a_vld), 0);
        chk("ack_id",  32'(a_id),  20);
        run(8);
        chk("ack_repub", 32'(a_vld), 1);

        // restart on the last group suppresses the publish and resets the cadence
        wait_pos(int'(NGRP) - 1);
        scan_restart = 1;
        step();
        scan_restart = 0;
        chk("rs_done", 32'(a_done), 0);
        found = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (a_done && found == 0) found = i;
        end
        chk("rs_gap", found, 8);

        // single-group instance publishes the live max each cycle
        clear_srcs();
        set_src(3,  8'h22, 1'b0);
        set_src(9,  8'h90, 1'b1);
        set_src(12, 8'h90, 1'b0);
        thresh = 8'h00;
        step();
        chk("one_id",   32'(s_id),   9);
        chk("one_done", 32'(s_done), 1);

        // reset mid-sweep
        run(3);
        rst = 1;
        step();
        chk("mrst_vld",  32'(a_vld),  0);
        chk("mrst_id",   32'(a_id),   0);
        chk("mrst_il",   32'(a_il),   0);
        chk("mrst_done", 32'(a_done), 0);
        rst = 0;

        // random traffic
        for (int k = 0; k < int'(INTNUM); k++) begin
            req[k]       = ($urandom_range(0, 2) == 0);
            il[k*8 +: 8] = 8'($urandom);
            hv[k]        = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 3000; i++) begin
            rnd_inputs();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
